// File: rtl/cond_exec_ctrl.sv
// Conditional-execution issue gate for the ID stage: owns NZCV, tracks in-flight flag writers,
// stalls/issues/kills conditional instructions and sequences the post-branch flush.
// Optional macro COND_FLAG_BYPASS_EN evaluates the condition on the writeback value in the same cycle.
module cond_exec_ctrl #(
  parameter int PEND_MAX  = 3,
  parameter int FLUSH_LEN = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       id_valid,
  input  logic [3:0] id_cond,
  input  logic       id_s,
  input  logic       id_is_branch,
  input  logic       freeze,
  input  logic       exe_flag_wr,
  input  logic [3:0] exe_status,
  output logic [3:0] status,
  output logic       id_stall,
  output logic       id_exec,
  output logic       id_kill,
  output logic       flush,
  output logic [2:0] pend_cnt,
  output logic [1:0] ctrl_state
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [2:0] PEND_LIMIT = 3'(PEND_MAX);
  localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_LEN - 1);

  state_t     state, next_state;
  logic [1:0] flush_cnt, next_flush_cnt;
  logic       bypass_hit;
  logic [3:0] eval_flags;
  logic       needs_flags, hazard, full, cond_ok;
  logic       pend_inc;

  function automatic logic cond_true(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cond)
      4'd0:    cond_true = z;
      4'd1:    cond_true = ~z;
      4'd2:    cond_true = c;
      4'd3:    cond_true = ~c;
      4'd4:    cond_true = n;
      4'd5:    cond_true = ~n;
      4'd6:    cond_true = v;
      4'd7:    cond_true = ~v;
      4'd8:    cond_true = c & ~z;
      4'd9:    cond_true = ~c | z;
      4'd10:   cond_true = (n == v);
      4'd11:   cond_true = (n != v);
      4'd12:   cond_true = ~z & (n == v);
      4'd13:   cond_true = z | (n != v);
      4'd14:   cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  endfunction

`ifdef COND_FLAG_BYPASS_EN
  // The last outstanding writer is landing now, so its value is already the one to test.
  assign bypass_hit = exe_flag_wr & (pend_cnt == 3'd1);
  assign eval_flags = bypass_hit ? exe_status : status;
`else
  assign bypass_hit = 1'b0;
  assign eval_flags = status;
`endif

  assign needs_flags = (id_cond[3:1] != 3'b111);
  assign hazard      = id_valid & needs_flags & (pend_cnt != 3'd0) & ~bypass_hit;
  assign full        = id_valid & id_s & ~id_is_branch & (pend_cnt == PEND_LIMIT);
  assign cond_ok     = cond_true(id_cond, eval_flags);
  assign flush       = (state == FLUSH);
  assign ctrl_state  = state;
  assign pend_inc    = id_exec & id_s & ~id_is_branch;

  always_comb begin
    next_state     = state;
    next_flush_cnt = flush_cnt;
    id_stall       = 1'b0;
    id_exec        = 1'b0;
    id_kill        = 1'b0;
    case (state)
      FLUSH: begin
        if (flush_cnt == 2'd0) next_state = RUN;
        else                   next_flush_cnt = flush_cnt - 2'd1;
      end
      default: begin
        if (!freeze) begin
          if (hazard | full) begin
            id_stall   = 1'b1;
            next_state = STALL;
          end else if (id_valid) begin
            next_state = RUN;
            if (cond_ok) begin
              id_exec = 1'b1;
              if (id_is_branch) begin
                next_state     = FLUSH;
                next_flush_cnt = FLUSH_LAST;
              end
            end else begin
              id_kill = 1'b1;
            end
          end else begin
            next_state = RUN;
          end
        end
      end
    endcase
    if (rst) begin
      id_stall = 1'b0;
      id_exec  = 1'b0;
      id_kill  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      flush_cnt <= 2'd0;
    end else begin
      state     <= next_state;
      flush_cnt <= next_flush_cnt;
    end
  end

  // A writeback with nothing pending is a protocol error: the count saturates at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      status   <= 4'd0;
      pend_cnt <= 3'd0;
    end else begin
      if (exe_flag_wr) status <= exe_status;
      case ({pend_inc, exe_flag_wr})
        2'b10:   pend_cnt <= pend_cnt + 3'd1;
        2'b01:   if (pend_cnt != 3'd0) pend_cnt <= pend_cnt - 3'd1;
        default: pend_cnt <= pend_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_cond_exec_ctrl.sv
// Bench for cond_exec_ctrl: directed test-plan steps then random traffic, all checked
// against a cycle-level behavioural model of the issue rules.
module tb_cond_exec_ctrl;

  localparam int PEND_MAX  = 3;
  localparam int FLUSH_LEN = 1;

  logic       clk = 1'b0;
  logic       rst, id_valid, id_s, id_is_branch, freeze, exe_flag_wr;
  logic [3:0] id_cond, exe_status;
  logic [3:0] status;
  logic       id_stall, id_exec, id_kill, flush;
  logic [2:0] pend_cnt;
  logic [1:0] ctrl_state;

  int vectors    = 0;
  int miscompares = 0;

  int m_status, m_pend, m_flush_left;
  bit m_stalled;

  cond_exec_ctrl #(.PEND_MAX(PEND_MAX), .FLUSH_LEN(FLUSH_LEN)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_cond(id_cond), .id_s(id_s),
    .id_is_branch(id_is_branch), .freeze(freeze), .exe_flag_wr(exe_flag_wr),
    .exe_status(exe_status), .status(status), .id_stall(id_stall), .id_exec(id_exec),
    .id_kill(id_kill), .flush(flush), .pend_cnt(pend_cnt), .ctrl_state(ctrl_state)
  );

  always #5 clk = ~clk;

  function automatic bit cond_holds(int c, int f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    bit ge = (n == v);
    case (c)
      0: return z;        1: return !z;
      2: return cy;       3: return !cy;
      4: return n;        5: return !n;
      6: return v;        7: return !v;
      8: return cy && !z; 9: return !cy || z;
      10: return ge;      11: return !ge;
      12: return !z && ge; 13: return z || !ge;
      14: return 1;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vectors++;
    assert (observed === expected) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    m_status = 0; m_pend = 0; m_flush_left = 0; m_stalled = 0;
  endtask

  // Drive one cycle of inputs, check the model's view of this cycle, then advance both.
  task automatic applyStimulus(input bit r, input bit v, input int c, input bit s, input bit b,
                               input bit fz, input bit wr, input int es);
    bit byp, stall_e, exec_e, kill_e, ok;
    int flags, nxt;
    rst = r; id_valid = v; id_cond = 4'(c); id_s = s; id_is_branch = b;
    freeze = fz; exe_flag_wr = wr; exe_status = 4'(es);
    #1;
    stall_e = 0; exec_e = 0; kill_e = 0;
`ifdef COND_FLAG_BYPASS_EN
    byp = wr && (m_pend == 1);
`else
    byp = 0;
`endif
    if (!r && m_flush_left == 0 && !fz) begin
      if ((v && c < 14 && m_pend != 0 && !byp) || (v && s && !b && m_pend == PEND_MAX))
        stall_e = 1;
      else if (v) begin
        flags = byp ? es : m_status;
        ok = cond_holds(c, flags);
        exec_e = ok; kill_e = !ok;
      end
    end
    checkOutput("status", status, m_status);
    checkOutput("pend_cnt", pend_cnt, m_pend);
    checkOutput("flush", flush, m_flush_left > 0);
    checkOutput("ctrl_state", ctrl_state, m_flush_left > 0 ? 2 : (m_stalled ? 1 : 0));
    checkOutput("id_stall", id_stall, stall_e);
    checkOutput("id_exec", id_exec, exec_e);
    checkOutput("id_kill", id_kill, kill_e);
    @(posedge clk);
    if (r) modelReset();
    else begin
      if (wr) m_status = es;
      nxt = m_pend + ((exec_e && s && !b) ? 1 : 0) - (wr ? 1 : 0);
      m_pend = (nxt < 0) ? 0 : nxt;
      if (m_flush_left > 0) begin
        m_flush_left--;
        m_stalled = 0;
      end else begin
        if (!fz) m_stalled = stall_e;
        if (exec_e && b) m_flush_left = FLUSH_LEN;
      end
    end
    #1;
  endtask

  initial begin
    rst = 1; id_valid = 0; id_cond = 0; id_s = 0; id_is_branch = 0;
    freeze = 0; exe_flag_wr = 0; exe_status = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset then unconditional issue.
    applyStimulus(1, 0, 14, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 14, 0, 0, 0, 0, 0);
    // ADDS then BEQ waiting on its flags, then taken branch flush.
    applyStimulus(0, 1, 14, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 1, 0, 1, 4'b0100);
    applyStimulus(0, 1, 0, 0, 1, 0, 0, 0);
    applyStimulus(0, 1, 14, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    // GE/LT against N=1,V=0, and "never" while a writer is pending.
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'b1000);
    applyStimulus(0, 1, 10, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 11, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 14, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 15, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 4'b1000);
    // Fill the scoreboard, block the fourth writer, release with one writeback.
    repeat (3) applyStimulus(0, 1, 14, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 14, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 14, 1, 0, 0, 1, 4'b0011);
    applyStimulus(0, 1, 14, 1, 0, 0, 0, 0);
    // Freeze holds issue but writeback still lands.
    applyStimulus(0, 1, 14, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 14, 0, 0, 1, 1, 4'b0110);
    // Taken branch with two pending, then reset in the flush cycle.
    applyStimulus(0, 1, 14, 0, 1, 0, 0, 0);
    applyStimulus(1, 1, 14, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Random traffic; writebacks only when something is pending keeps it mostly legal.
    for (int i = 0; i < 800; i++) begin
      bit r, v, s, b, fz, wr;
      r  = ($urandom_range(0, 59) == 0);
      v  = ($urandom_range(0, 5) != 0);
      s  = ($urandom_range(0, 2) == 0);
      b  = ($urandom_range(0, 5) == 0);
      fz = ($urandom_range(0, 6) == 0);
      wr = (m_pend > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 30) == 0);
      applyStimulus(r, v, int'($urandom_range(0, 15)), s, b, fz, wr,
                    int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
